// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-requester byte-serialising data memory arbiter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int NUM_REQ    = 2;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DATA_W = 32;

    function automatic int calc_beats(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester and memory-side bus of dmem_arbiter; slave is the arbiter's view, master the environment's.
interface dmem_arbiter_if #(
    parameter int ADDR_W = dmem_arb_pkg::DEF_ADDR_W,
    parameter int DATA_W = dmem_arb_pkg::DEF_DATA_W
) ();

    logic [1:0]          req_valid;
    logic [1:0]          req_ready;
    logic [1:0]          req_we;
    logic [2*ADDR_W-1:0] req_addr;
    logic [2*DATA_W-1:0] req_wdata;
    logic [1:0]          rsp_done;
    logic [DATA_W-1:0]   rsp_rdata;
    logic [ADDR_W-1:0]   mem_addr;
    logic                mem_we;
    logic [7:0]          mem_wdata;
    logic [7:0]          mem_rdata;
    logic                busy;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, mem_rdata,
        output req_ready, rsp_done, rsp_rdata, mem_addr, mem_we, mem_wdata, busy
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, mem_rdata,
        input  req_ready, rsp_done, rsp_rdata, mem_addr, mem_we, mem_wdata, busy
    );

endinterface

// File: rtl/arb_pick2.sv
// Combinational two-way picker producing a one-hot grant.
// DMEM_ARB_FIXED_PRIO_EN selects fixed priority (requester 0 first) instead of round-robin.
module arb_pick2
    import dmem_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic               last_grant_i,
    output logic [NUM_REQ-1:0] grant_o
);

`ifdef DMEM_ARB_FIXED_PRIO_EN
    always_comb begin
        grant_o = 2'b00;
        if (valid_i[0])      grant_o = 2'b01;
        else if (valid_i[1]) grant_o = 2'b10;
    end
`else
    // On a tie the requester that did not win last time goes first.
    always_comb begin
        grant_o = valid_i;
        if (valid_i == 2'b11) grant_o = last_grant_i ? 2'b01 : 2'b10;
    end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter that serialises one word access into BEATS byte cycles, MSB first.
// Arbitration policy is set by DMEM_ARB_FIXED_PRIO_EN inside arb_pick2.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input logic           clk,
    input logic           reset,
    dmem_arbiter_if.slave bus
);

    localparam int BEATS  = calc_beats(DATA_W);
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    state_e              state_q;
    logic [BEAT_W-1:0]   beat_q;
    logic                last_grant_q;
    logic                owner_q;
    logic                we_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [NUM_REQ-1:0]  rsp_done_q;
    logic [DATA_W-1:0]   rsp_rdata_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic                mem_we_q;
    logic [7:0]          mem_wdata_q;

    logic [NUM_REQ-1:0]  grant;
    logic [NUM_REQ-1:0]  ready;
    logic                win_idx;
    logic                sel_we;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic [DATA_W-1:0]   rdata_d;
    logic                last_beat;

    arb_pick2 u_pick (
        .valid_i      (bus.req_valid),
        .last_grant_i (last_grant_q),
        .grant_o      (grant)
    );

    always_comb begin
        ready     = (state_q == IDLE && !reset) ? grant : '0;
        win_idx   = grant[1];
        sel_we    = bus.req_we[win_idx];
        sel_addr  = bus.req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
        sel_wdata = bus.req_wdata[int'(win_idx)*DATA_W +: DATA_W];
        rdata_d   = (rdata_q << 8) | DATA_W'(bus.mem_rdata);
        last_beat = (beat_q == BEAT_W'(BEATS - 1));
    end

    // The memory-side outputs are registered one beat ahead so each beat is presented
    // for a full cycle starting right after the handshake edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            beat_q       <= '0;
            last_grant_q <= 1'b1;
            rsp_done_q   <= '0;
            rsp_rdata_q  <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            rsp_done_q <= '0;
            case (state_q)
                IDLE: begin
                    if (|(bus.req_valid & ready)) begin
                        owner_q      <= win_idx;
                        last_grant_q <= win_idx;
                        we_q         <= sel_we;
                        wdata_q      <= sel_wdata << 8;
                        beat_q       <= '0;
                        mem_addr_q   <= sel_addr;
                        mem_we_q     <= sel_we;
                        mem_wdata_q  <= sel_we ? sel_wdata[DATA_W-1 -: 8] : 8'h00;
                        state_q      <= XFER;
                    end
                end
                XFER: begin
                    rdata_q <= rdata_d;
                    if (last_beat) begin
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= '0;
                        mem_wdata_q <= '0;
                        rsp_done_q  <= NUM_REQ'(1) << owner_q;
                        rsp_rdata_q <= we_q ? '0 : rdata_d;
                        state_q     <= RESP;
                    end else begin
                        beat_q      <= beat_q + 1'b1;
                        mem_addr_q  <= mem_addr_q + 1'b1;
                        mem_wdata_q <= we_q ? wdata_q[DATA_W-1 -: 8] : 8'h00;
                        wdata_q     <= wdata_q << 8;
                    end
                end
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Reset gates the write strobe at once so an aborted beat never reaches memory.
    assign bus.req_ready = ready;
    assign bus.rsp_done  = rsp_done_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_we    = mem_we_q & ~reset;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a transaction-level model predicts grants, beats and responses.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    localparam int AW    = DEF_ADDR_W;
    localparam int DW    = DEF_DATA_W;
    localparam int NB    = DW / 8;
    localparam int DEPTH = 1 << AW;

    typedef struct { int cyc; bit we; int addr; logic [7:0] data; } beat_t;
    typedef struct { int cyc; int owner; logic [DW-1:0] rdata; } rsp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .reset(reset), .bus(bus));

    logic [7:0] tb_mem  [DEPTH];
    logic [7:0] ref_mem [DEPTH];
    always @(posedge clk) if (bus.mem_we === 1'b1) tb_mem[bus.mem_addr] <= bus.mem_wdata;
    assign bus.mem_rdata = tb_mem[bus.mem_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, errors = 0;
    beat_t exp_beat[$];
    beat_t mem_pend[$];
    rsp_t  exp_rsp[$];
    int    dut_grant[$];
    int    dut_hs[$];

    logic          pend   [2];
    logic          p_we   [2];
    logic [AW-1:0] p_addr [2];
    logic [DW-1:0] p_wdata[2];
    logic rst_req = 1'b1, mon_en = 1'b0, rr_last = 1'b1;
    int next_ok = 0, busy_from = -100, busy_to = -100, last_t = -1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic [1:0] model_pick(input logic [1:0] v);
`ifdef DMEM_ARB_FIXED_PRIO_EN
        if (v[0]) return 2'b01;
        return v;
`else
        if (v == 2'b11) return rr_last ? 2'b01 : 2'b10;
        return v;
`endif
    endfunction

    task automatic accept(input int w, input int t);
        logic [DW-1:0] rd;
        beat_t b;
        rr_last = (w == 1); pend[w] = 1'b0; last_t = t;
        next_ok = t + NB + 2; busy_from = t; busy_to = t + NB;
        rd = '0;
        for (int k = 0; k < NB; k++) begin
            b.cyc = t + k; b.we = p_we[w]; b.addr = (int'(p_addr[w]) + k) % DEPTH;
            b.data = p_wdata[w][DW-1-8*k -: 8];
            rd = (rd << 8) | DW'(ref_mem[b.addr]);
            exp_beat.push_back(b);
            if (p_we[w]) mem_pend.push_back(b);
        end
        exp_rsp.push_back('{cyc: t + NB, owner: w, rdata: p_we[w] ? '0 : rd});
    endtask

    task automatic cycle_step();
        int c;
        logic [1:0] pred;
        beat_t b;
        @(negedge clk);
        c = cyc;
        reset = rst_req;
        for (int i = 0; i < 2; i++) begin
            bus.req_valid[i] = pend[i];
            bus.req_we[i]    = p_we[i];
            bus.req_addr[i*AW +: AW]  = p_addr[i];
            bus.req_wdata[i*DW +: DW] = p_wdata[i];
        end
        if (reset) begin
            while (exp_beat.size() > 0 && exp_beat[$].cyc >= c) void'(exp_beat.pop_back());
            while (mem_pend.size() > 0 && mem_pend[$].cyc >= c) void'(mem_pend.pop_back());
            while (exp_rsp.size() > 0 && exp_rsp[$].cyc > c) void'(exp_rsp.pop_back());
            rr_last = 1'b1; next_ok = c + 2;
            if (busy_to > c) busy_to = c;
        end else begin
            while (mem_pend.size() > 0 && mem_pend[0].cyc <= c) begin
                b = mem_pend.pop_front();
                ref_mem[b.addr] = b.data;
            end
        end
        #1;
        pred = (!reset && c + 1 >= next_ok) ? model_pick({pend[1], pend[0]}) : 2'b00;
        chk("req_ready", 64'(bus.req_ready), 64'(pred));
        if (|(bus.req_ready & bus.req_valid)) begin
            dut_grant.push_back(bus.req_ready[1] ? 1 : 0);
            dut_hs.push_back(c + 1);
        end
        if (pred != 2'b00) accept(pred[1] ? 1 : 0, c + 1);
    endtask

    task automatic request(input int i, input logic we, input int addr, input logic [DW-1:0] wd);
        pend[i] = 1'b1; p_we[i] = we; p_addr[i] = AW'(addr); p_wdata[i] = wd;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((pend[0] || pend[1] || cyc + 1 < next_ok) && n < 200) begin
            cycle_step();
            n++;
        end
        if (n >= 200) begin
            checks++; errors++;
            $display("FAIL wait_idle: budget of 200 cycles expired at cycle %0d", cyc);
        end
    endtask

    // Monitor: pops expected beats and responses when their cycle comes round.
    initial begin
        beat_t b;
        rsp_t r;
        logic prev_rst = 1'b0;
        logic [DW-1:0] hold = '0;
        forever begin
            @(negedge clk);
            #2;
            if (mon_en) begin
                if (prev_rst) hold = '0;
                chk("busy", 64'(bus.busy), 64'(cyc >= busy_from && cyc <= busy_to));
                if (exp_beat.size() > 0 && exp_beat[0].cyc <= cyc) begin
                    b = exp_beat.pop_front();
                    chk("beat_we", 64'(bus.mem_we), 64'(b.we));
                    chk("beat_addr", 64'(bus.mem_addr), 64'(b.addr));
                    if (b.we) chk("beat_wdata", 64'(bus.mem_wdata), 64'(b.data));
                end else if (!reset) begin
                    chk("idle_mem", 64'({bus.mem_we, bus.mem_addr, bus.mem_wdata}), 64'(0));
                end
                if (exp_rsp.size() > 0 && exp_rsp[0].cyc <= cyc) begin
                    r = exp_rsp.pop_front();
                    chk("rsp_done", 64'(bus.rsp_done), 64'(2'b01 << r.owner));
                    chk("rsp_rdata", 64'(bus.rsp_rdata), 64'(r.rdata));
                    hold = r.rdata;
                end else begin
                    chk("rsp_idle", 64'(bus.rsp_done), 64'(0));
                    chk("rsp_hold", 64'(bus.rsp_rdata), 64'(hold));
                end
            end
            prev_rst = reset;
        end
    end

    initial begin
        logic [7:0] v, keep10, keep11;
        int n;
        for (int i = 0; i < DEPTH; i++) begin
            v = 8'($urandom_range(0, 255));
            tb_mem[i] = v; ref_mem[i] = v;
        end
        for (int i = 0; i < 2; i++) request(i, 1'b0, 0, '0);
        pend[0] = 1'b0; pend[1] = 1'b0;
        reset = 1'b1;
        cycle_step(); cycle_step();
        mon_en = 1'b1;
        cycle_step();
        rst_req = 1'b0;
        cycle_step();

        request(0, 1'b1, 4, 32'hDEADBEEF);
        wait_idle();
        chk("wr_b4", 64'(tb_mem[4]), 64'h DE); chk("wr_b5", 64'(tb_mem[5]), 64'h AD);
        chk("wr_b6", 64'(tb_mem[6]), 64'h BE); chk("wr_b7", 64'(tb_mem[7]), 64'h EF);
        request(1, 1'b0, 4, '0);
        wait_idle();
        chk("rd_word", 64'(bus.rsp_rdata), 64'h DEADBEEF);

        request(0, 1'b1, 30, 32'h11223344);
        wait_idle();
        chk("wrap_b30", 64'(tb_mem[30]), 64'h11); chk("wrap_b31", 64'(tb_mem[31]), 64'h22);
        chk("wrap_b0", 64'(tb_mem[0]), 64'h33);   chk("wrap_b1", 64'(tb_mem[1]), 64'h44);
        request(1, 1'b0, 30, '0);
        wait_idle();
        chk("wrap_rd", 64'(bus.rsp_rdata), 64'h11223344);

        // Contention: both valid through reset, re-requesting right after each grant.
        rst_req = 1'b1;
        request(0, 1'b0, 16, '0); request(1, 1'b0, 20, '0);
        cycle_step(); cycle_step();
        rst_req = 1'b0;
        dut_grant.delete();
        n = 0;
        while (dut_grant.size() < 4 && n < 60) begin
            cycle_step();
            for (int i = 0; i < 2; i++)
                if (!pend[i]) request(i, 1'b0, $urandom_range(0, DEPTH-1), '0);
            n++;
        end
        pend[0] = 1'b0; pend[1] = 1'b0;
        if (dut_grant.size() < 4) begin
            checks++; errors++;
            $display("FAIL contention: only %0d grants, required 4", dut_grant.size());
        end else begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
            for (int i = 0; i < 3; i++) chk("grant_order", 64'(dut_grant[i]), 64'(0));
`else
            for (int i = 0; i < 4; i++) chk("grant_order", 64'(dut_grant[i]), 64'(i % 2));
`endif
        end
        wait_idle();

        // Reset during beat 2 of a write.
        keep10 = tb_mem[10]; keep11 = tb_mem[11];
        last_t = -1;
        request(0, 1'b1, 8, 32'hAABBCCDD);
        n = 0;
        while (last_t < 0 && n < 20) begin cycle_step(); n++; end
        while (cyc + 1 < last_t + 2) cycle_step();
        rst_req = 1'b1;
        cycle_step();
        rst_req = 1'b0;
        cycle_step();
        chk("abort_busy", 64'(bus.busy), 64'(0));
        wait_idle();
        chk("abort_b8", 64'(tb_mem[8]), 64'h AA);  chk("abort_b9", 64'(tb_mem[9]), 64'h BB);
        chk("abort_b10", 64'(tb_mem[10]), 64'(keep10));
        chk("abort_b11", 64'(tb_mem[11]), 64'(keep11));

        // Back-to-back reads from requester 0.
        dut_hs.delete();
        request(0, 1'b0, 12, '0);
        n = 0;
        while (dut_hs.size() < 1 && n < 20) begin cycle_step(); n++; end
        request(0, 1'b0, 13, '0);
        while (dut_hs.size() < 2 && n < 40) begin cycle_step(); n++; end
        if (dut_hs.size() < 2) begin
            checks++; errors++;
            $display("FAIL b2b: %0d handshakes seen, required 2", dut_hs.size());
        end else chk("b2b_spacing", 64'(dut_hs[1] - dut_hs[0]), 64'(NB + 2));
        wait_idle();

        // Random traffic with occasional resets.
        for (int t = 0; t < 500; t++) begin
            for (int i = 0; i < 2; i++)
                if (!pend[i] && $urandom_range(0, 3) == 0)
                    request(i, 1'($urandom_range(0, 1)), $urandom_range(0, DEPTH-1), DW'($urandom));
            rst_req = ($urandom_range(0, 149) == 0);
            cycle_step();
        end
        rst_req = 1'b0;
        wait_idle();
        cycle_step();
        for (int i = 0; i < DEPTH; i++) chk("final_mem", 64'(tb_mem[i]), 64'(ref_mem[i]));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
